jk_updown_counter: RTL and testbench



---
 rtl/jk_updown_counter_pkg.sv | 21 ++
 rtl/jk_updown_counter_if.sv | 23 ++
 rtl/jk_updown_counter_bit_cell.sv | 32 +++
 rtl/jk_updown_counter.sv | 74 +++++++
 tb/tb_jk_updown_counter.sv | 137 +++++++++++++
 5 files changed

// File: rtl/jk_updown_counter_pkg.sv
// rtl/jk_updown_counter_pkg.sv - shared JK encodings and counter defaults
package jk_updown_counter_pkg;

    localparam int WIDTH_DEFAULT = 4;
    localparam int MOD_DEFAULT   = 10;
    localparam int MAX_CNT       = MOD_DEFAULT - 1;

    // {J,K} encodings, also used by the single-cell bench
    typedef enum logic [1:0] {
        JK_HOLD   = 2'b00,
        JK_RESET  = 2'b01,
        JK_SET    = 2'b10,
        JK_TOGGLE = 2'b11
    } jk_mode_t;

    localparam logic [1:0] JK_HOLD_ENC   = 2'b00;
    localparam logic [1:0] JK_RESET_ENC  = 2'b01;
    localparam logic [1:0] JK_SET_ENC    = 2'b10;
    localparam logic [1:0] JK_TOGGLE_ENC = 2'b11;

endpackage

// File: rtl/jk_updown_counter_if.sv
// rtl/jk_updown_counter_if.sv - control/status bundle of the JK up/down counter
interface jk_updown_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] Q_bar;
    logic             tc;
    logic             load_err;

    modport master (
        output en, up, load, load_val,
        input  Q, Q_bar, tc, load_err
    );

    modport slave (
        input  en, up, load, load_val,
        output Q, Q_bar, tc, load_err
    );
endinterface

// File: rtl/jk_updown_counter_bit_cell.sv
// rtl/jk_updown_counter_bit_cell.sv - single JK flip-flop cell, async active-high reset
module jk_bit_cell
    import jk_updown_counter_pkg::*;
(
    input  logic Clk,
    input  logic reset,
    input  logic J,
    input  logic K,
    output logic Q,
    output logic Q_bar
);

    logic r_q;

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            r_q <= 1'b0;
        end else begin
            case (jk_mode_t'({J, K}))
                JK_HOLD:   r_q <= r_q;
                JK_RESET:  r_q <= 1'b0;
                JK_SET:    r_q <= 1'b1;
                JK_TOGGLE: r_q <= ~r_q;
                default:   r_q <= r_q;
            endcase
        end
    end

    assign Q     = r_q;
    assign Q_bar = ~r_q;

endmodule

// File: rtl/jk_updown_counter.sv
// rtl/jk_updown_counter.sv - modulo-MOD up/down counter built from JK cells
module jk_updown_counter
    import jk_updown_counter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int MOD   = MOD_DEFAULT
) (
    input  logic Clk,
    input  logic reset,
    jk_updown_counter_if.slave bus
);

    localparam logic [WIDTH-1:0] L_MAX     = WIDTH'(MOD - 1);
    // one extra bit so MOD == 2**WIDTH still compares correctly
    localparam logic [WIDTH:0]   L_MOD_EXT = (WIDTH + 1)'(MOD);

    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_qb;
    logic [WIDTH-1:0] w_d;
    logic [WIDTH-1:0] w_j;
    logic [WIDTH-1:0] w_k;
    logic             w_load_bad;
    logic             w_q_oor;
    logic             r_load_err;

    assign w_load_bad = ({1'b0, bus.load_val} >= L_MOD_EXT);
    assign w_q_oor    = (w_q > L_MAX);

    always_comb begin
        w_d = w_q;
        if (bus.load) begin
            w_d = w_load_bad ? '0 : bus.load_val;
        end else if (bus.en) begin
            if (bus.up) begin
                w_d = (w_q >= L_MAX) ? '0 : w_q + 1'b1;
            end else begin
                w_d = ((w_q == '0) || w_q_oor) ? L_MAX : w_q - 1'b1;
            end
        end
    end

    // excitation from the target state keeps J=K=1 impossible
    assign w_j = w_d & ~w_q;
    assign w_k = ~w_d & w_q;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_cell
            jk_bit_cell u_cell (
                .Clk   (Clk),
                .reset (reset),
                .J     (w_j[gi]),
                .K     (w_k[gi]),
                .Q     (w_q[gi]),
                .Q_bar (w_qb[gi])
            );
        end
    endgenerate

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            r_load_err <= 1'b0;
        end else begin
            r_load_err <= bus.load & w_load_bad;
        end
    end

    assign bus.Q        = w_q;
    assign bus.Q_bar    = w_qb;
    assign bus.load_err = r_load_err;
    assign bus.tc       = bus.en & ~bus.load &
                          ((bus.up & (w_q == L_MAX)) | (~bus.up & (w_q == '0)));

endmodule

// File: tb/tb_jk_updown_counter.sv
// tb/tb_jk_updown_counter.sv - directed plus random bench for jk_updown_counter
module tb_jk_updown_counter;
    import jk_updown_counter_pkg::*;

    localparam int W = 4;
    localparam int M = 10;

    logic Clk   = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    bit   chk_on   = 1'b0;
    int   m_q      = 0;
    int   m_err    = 0;

    jk_updown_counter_if #(.WIDTH(W)) bus ();

    jk_updown_counter #(.WIDTH(W), .MOD(M)) dut (
        .Clk   (Clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_q"},     int'(bus.Q), m_q);
        chk({tag, "_qbar"},  int'(bus.Q_bar), int'(~m_q) & 15);
        chk({tag, "_err"},   int'(bus.load_err), m_err);
    endtask

    // tc is checked before the edge, then the model advances and Q is checked after it
    task automatic tick(input string tag);
        int nq;
        int ne;
        int exp_tc;
        #1;
        exp_tc = (bus.en && !bus.load &&
                  ((bus.up && m_q == M - 1) || (!bus.up && m_q == 0))) ? 1 : 0;
        chk({tag, "_tc"}, int'(bus.tc), exp_tc);
        nq = m_q;
        ne = 0;
        if (bus.load) begin
            if (int'(bus.load_val) < M) nq = int'(bus.load_val);
            else begin nq = 0; ne = 1; end
        end else if (bus.en) begin
            nq = bus.up ? (m_q + 1) % M : (m_q + M - 1) % M;
        end
        @(posedge Clk);
        #1;
        m_q   = nq;
        m_err = ne;
        chk_state(tag);
    endtask

    always @(negedge Clk) begin
        if (chk_on) begin
            chk("no_jk11", int'(dut.w_j & dut.w_k), 0);
            chk("qbar_inv", int'(bus.Q_bar ^ bus.Q), 15);
            chk("q_range", int'(bus.Q < 4'(M)), 1);
        end
    end

    initial begin
        bus.en = 1'b1; bus.up = 1'b1; bus.load = 1'b0; bus.load_val = '0;
        #2;
        chk_state("rst_async");
        chk_on = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        chk_state("rst_hold");
        reset = 1'b0;

        for (int i = 0; i < 12; i++) tick("up_count");

        bus.en = 1'b0; bus.load = 1'b1; bus.load_val = 4'd3;
        tick("load3");
        bus.load = 1'b0; bus.en = 1'b1; bus.up = 1'b0;
        for (int i = 0; i < 5; i++) tick("down_count");

        bus.en = 1'b0; bus.load = 1'b1; bus.load_val = 4'd12;
        tick("load_bad");
        bus.load = 1'b0;
        tick("load_err_clr");
        bus.en = 1'b1; bus.up = 1'b1; bus.load = 1'b1; bus.load_val = 4'd7;
        tick("load_beats_en");
        chk("load7_value", int'(bus.Q), 7);

        bus.en = 1'b0; bus.load_val = 4'd5;
        tick("load5");
        bus.load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.up = ~bus.up;
            tick("hold");
        end
        chk("hold_value", int'(bus.Q), 5);
        bus.load = 1'b1; bus.load_val = 4'd9;
        tick("load9");
        bus.load = 1'b0; bus.en = 1'b1; bus.up = 1'b0;
        tick("dir_flip");
        chk("dir_flip_value", int'(bus.Q), 8);

        bus.en = 1'b0; bus.load = 1'b1; bus.load_val = 4'd15;
        tick("load15");
        bus.load = 1'b0;
        #3;
        reset = 1'b1;
        #1;
        m_q = 0; m_err = 0;
        chk_state("rst_mid");
        @(posedge Clk);
        #1;
        chk_state("rst_mid_hold");
        reset = 1'b0;

        for (int i = 0; i < 300; i++) begin
            bus.en       = 1'($urandom_range(0, 3) != 0);
            bus.up       = 1'($urandom);
            bus.load     = 1'($urandom_range(0, 7) == 0);
            bus.load_val = 4'($urandom_range(0, 15));
            tick("random");
        end

        chk_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
